// File: rtl/branch_pkg.sv
// Shared encodings for control-flow resolution: branch funct3 codes,
// ALU flag bit positions and the resolver state type.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Bit positions inside the ALU {o,c,n,z} flag vector.
  localparam int FLAG_O = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {IDLE, REDIRECT} br_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode from the rs1-rs2 subtract flags; purely combinational,
// zero latency, no flow control. Reserved funct3 codes resolve as not taken.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       taken
);

  logic lt_signed;

  assign lt_signed = flags[FLAG_N] ^ flags[FLAG_O];

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = flags[FLAG_Z];
      F3_BNE:  taken = ~flags[FLAG_Z];
      F3_BLT:  taken = lt_signed;
      F3_BGE:  taken = ~lt_signed;
      F3_BLTU: taken = ~flags[FLAG_C];
      F3_BGEU: taken = flags[FLAG_C];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: mispredict redirect + flushes registered one cycle
// after resolve; stall defers resolution and freezes an in-flight redirect.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [3:0]       alu_flags,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic             stall,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             squash_ex,
  output logic [XLEN-1:0]  link_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  br_state_t       state;
  logic            cond_taken;
  logic            is_cf;
  logic            actual_taken;
  logic            resolve;
  logic            mispredict;
  logic [XLEN-1:0] fallthru;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] corrected;

  branch_cond u_cond (
    .funct3 (ex_funct3),
    .flags  (alu_flags),
    .taken  (cond_taken)
  );

  assign fallthru = ex_pc + XLEN'(4);
  assign link_pc  = fallthru;
  assign jalr_sum = ex_rs1 + ex_imm;

  // JALR wins over JAL and branch when decode sets more than one kind.
  always_comb begin
    target = ex_pc + ex_imm;
    if (ex_is_jalr) target = {jalr_sum[XLEN-1:1], 1'b0};
  end

  assign is_cf        = ex_is_branch | ex_is_jal | ex_is_jalr;
  assign actual_taken = ex_is_jalr | ex_is_jal | (ex_is_branch & cond_taken);
  assign mispredict   = (actual_taken != ex_pred_taken) |
                        (actual_taken & (target != ex_pred_target));
  assign corrected    = actual_taken ? target : fallthru;
  assign resolve      = ex_valid & is_cf & ~stall & (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      squash_ex      <= 1'b0;
      redirect_pc    <= '0;
      br_count       <= '0;
      mispred_count  <= '0;
    end else if (state == IDLE) begin
      if (resolve) begin
        if (br_count != '1) br_count <= br_count + CNT_W'(1);
        if (mispredict) begin
          if (mispred_count != '1) mispred_count <= mispred_count + CNT_W'(1);
          state          <= REDIRECT;
          redirect_pc    <= corrected;
          redirect_valid <= 1'b1;
          flush_if       <= 1'b1;
          flush_id       <= 1'b1;
          squash_ex      <= 1'b1;
        end
      end
    end else if (!stall) begin
      // Redirect has been consumed; EX now holds wrong-path work and is ignored.
      state          <= IDLE;
      redirect_valid <= 1'b0;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      squash_ex      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table for decode/target/mispredict,
// hand sequences for stall deferral, stall during redirect, async reset and saturation.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [3:0]  alu_flags;
  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_pred_target;
  logic        ex_pred_taken, stall;

  logic        redirect_valid, flush_if, flush_id, squash_ex;
  logic [31:0] redirect_pc, link_pc, br_count, mispred_count;

  logic        rv4, fi4, fd4, sq4;
  logic [31:0] rpc4, lpc4;
  logic [3:0]  br4, mis4;

  int checks = 0;
  int errors = 0;
  int br_e   = 0;
  int mis_e  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
    .alu_flags(alu_flags), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_if(flush_if),
    .flush_id(flush_id), .squash_ex(squash_ex), .link_pc(link_pc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
    .alu_flags(alu_flags), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .stall(stall),
    .redirect_valid(rv4), .redirect_pc(rpc4), .flush_if(fi4),
    .flush_id(fd4), .squash_ex(sq4), .link_pc(lpc4),
    .br_count(br4), .mispred_count(mis4)
  );

  typedef struct {
    logic        valid, br, jal, jalr;
    logic [2:0]  f3;
    logic [3:0]  fl;
    logic [31:0] pc, imm, rs1;
    logic        pt;
    logic [31:0] ptgt;
    logic        red;
    logic [31:0] rpc;
  } vec_t;

  localparam int NV = 23;
  vec_t vt[NV];

  function automatic vec_t mk(input logic valid, br, jal, jalr, input logic [2:0] f3,
                              input logic [3:0] fl, input logic [31:0] pc, imm, rs1,
                              input logic pt, input logic [31:0] ptgt,
                              input logic red, input logic [31:0] rpc);
    vec_t v;
    v.valid = valid; v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3; v.fl = fl;
    v.pc = pc; v.imm = imm; v.rs1 = rs1; v.pt = pt; v.ptgt = ptgt;
    v.red = red; v.rpc = rpc;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_valid = v.valid; ex_is_branch = v.br; ex_is_jal = v.jal; ex_is_jalr = v.jalr;
    ex_funct3 = v.f3; alu_flags = v.fl; ex_pc = v.pc; ex_imm = v.imm; ex_rs1 = v.rs1;
    ex_pred_taken = v.pt; ex_pred_target = v.ptgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string name, input logic exp);
    chk1({name, ".redirect_valid"}, redirect_valid, exp);
    chk1({name, ".flush_if"}, flush_if, exp);
    chk1({name, ".flush_id"}, flush_id, exp);
    chk1({name, ".squash_ex"}, squash_ex, exp);
  endtask

  task automatic chk_cnt(input string name);
    chk32({name, ".br_count"}, br_count, 32'(br_e));
    chk32({name, ".mispred_count"}, mispred_count, 32'(mis_e));
  endtask

  initial begin
    //        valid br jal jalr f3      flags    pc            imm        rs1        pt ptgt          red rpc
    vt[0]  = mk(1, 1, 0, 0, 3'b000, 4'b0101, 32'h100,      32'h20,    32'h0,     0, 32'h0,        1, 32'h120);
    vt[1]  = mk(1, 1, 0, 0, 3'b000, 4'b0100, 32'h100,      32'h20,    32'h0,     0, 32'h0,        0, 32'h0);
    vt[2]  = mk(1, 1, 0, 0, 3'b001, 4'b0100, 32'h100,      32'h20,    32'h0,     1, 32'h120,      0, 32'h0);
    vt[3]  = mk(1, 1, 0, 0, 3'b001, 4'b0101, 32'h100,      32'h20,    32'h0,     1, 32'h120,      1, 32'h104);
    vt[4]  = mk(1, 1, 0, 0, 3'b100, 4'b0110, 32'h100,      32'h20,    32'h0,     1, 32'h120,      0, 32'h0);
    vt[5]  = mk(1, 1, 0, 0, 3'b110, 4'b0110, 32'h100,      32'h20,    32'h0,     0, 32'h0,        0, 32'h0);
    vt[6]  = mk(1, 1, 0, 0, 3'b101, 4'b0110, 32'h100,      32'h20,    32'h0,     1, 32'h120,      1, 32'h104);
    vt[7]  = mk(1, 1, 0, 0, 3'b101, 4'b1010, 32'h100,      32'h20,    32'h0,     0, 32'h0,        1, 32'h120);
    vt[8]  = mk(1, 1, 0, 0, 3'b100, 4'b1000, 32'h100,      32'h20,    32'h0,     1, 32'h200,      1, 32'h120);
    vt[9]  = mk(1, 1, 0, 0, 3'b111, 4'b0100, 32'h100,      32'h20,    32'h0,     1, 32'h120,      0, 32'h0);
    vt[10] = mk(1, 1, 0, 0, 3'b111, 4'b0000, 32'h100,      32'h20,    32'h0,     0, 32'h0,        0, 32'h0);
    vt[11] = mk(1, 1, 0, 0, 3'b010, 4'b0101, 32'h100,      32'h20,    32'h0,     0, 32'h0,        0, 32'h0);
    vt[12] = mk(1, 1, 0, 0, 3'b011, 4'b1111, 32'h100,      32'h20,    32'h0,     0, 32'h0,        0, 32'h0);
    vt[13] = mk(1, 0, 1, 0, 3'b000, 4'b0000, 32'h100,      32'h20,    32'h0,     1, 32'h120,      0, 32'h0);
    vt[14] = mk(1, 0, 1, 0, 3'b000, 4'b0000, 32'h100,      32'h20,    32'h0,     0, 32'h0,        1, 32'h120);
    vt[15] = mk(1, 0, 0, 1, 3'b000, 4'b0000, 32'h100,      32'h4,     32'h1003,  1, 32'h1006,     0, 32'h0);
    vt[16] = mk(1, 0, 0, 1, 3'b000, 4'b0000, 32'h100,      32'h4,     32'h1003,  1, 32'h1000,     1, 32'h1006);
    vt[17] = mk(1, 1, 1, 1, 3'b000, 4'b0100, 32'h100,      32'h4,     32'h1003,  1, 32'h1006,     0, 32'h0);
    vt[18] = mk(1, 1, 1, 0, 3'b000, 4'b0100, 32'h100,      32'h20,    32'h0,     1, 32'h120,      0, 32'h0);
    vt[19] = mk(1, 0, 1, 0, 3'b000, 4'b0000, 32'hFFFFFFF0, 32'h20,    32'h0,     0, 32'h0,        1, 32'h10);
    vt[20] = mk(1, 1, 0, 0, 3'b000, 4'b0100, 32'hFFFFFFFC, 32'h8,     32'h0,     1, 32'h4,        1, 32'h0);
    vt[21] = mk(0, 1, 0, 0, 3'b000, 4'b0101, 32'h100,      32'h20,    32'h0,     0, 32'h0,        0, 32'h0);
    vt[22] = mk(1, 1, 0, 0, 3'b000, 4'b0100, 32'h100,      32'h20,    32'h0,     0, 32'h999,      0, 32'h0);

    rst_n = 1'b0;
    stall = 1'b0;
    drive(mk(0, 0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0));
    tick();
    tick();
    chk_ctl("reset", 1'b0);
    chk32("reset.redirect_pc", redirect_pc, 32'h0);
    chk_cnt("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(vt[i]);
      #1;
      chk32({nm, ".link_pc"}, link_pc, vt[i].pc + 32'd4);
      tick();
      if (vt[i].valid && (vt[i].br || vt[i].jal || vt[i].jalr)) br_e++;
      if (vt[i].red) mis_e++;
      chk_ctl(nm, vt[i].red);
      if (vt[i].red) chk32({nm, ".redirect_pc"}, redirect_pc, vt[i].rpc);
      chk_cnt(nm);
      ex_valid = 1'b0;
      tick();
      chk1({nm, ".back_idle"}, redirect_valid, 1'b0);
    end

    // Resolve seen while stalled waits for the first unstalled cycle.
    drive(vt[0]);
    stall = 1'b1;
    tick();
    chk1("defer.c1", redirect_valid, 1'b0);
    tick();
    chk1("defer.c2", redirect_valid, 1'b0);
    chk_cnt("defer.held");
    stall = 1'b0;
    tick();
    br_e++;
    mis_e++;
    chk_ctl("defer.fire", 1'b1);
    chk32("defer.redirect_pc", redirect_pc, 32'h120);
    chk_cnt("defer.fire");
    ex_valid = 1'b0;
    tick();

    // Three stall cycles during REDIRECT with a wrong-path mispredict sitting in EX.
    drive(vt[3]);
    tick();
    br_e++;
    mis_e++;
    chk1("hold.c1", redirect_valid, 1'b1);
    chk32("hold.pc1", redirect_pc, 32'h104);
    stall = 1'b1;
    drive(vt[19]);
    for (int c = 2; c <= 3; c++) begin
      tick();
      chk_ctl($sformatf("hold.c%0d", c), 1'b1);
      chk32($sformatf("hold.pc%0d", c), redirect_pc, 32'h104);
    end
    tick();
    chk1("hold.c4", redirect_valid, 1'b1);
    stall = 1'b0;
    tick();
    ex_valid = 1'b0;
    chk_ctl("hold.done", 1'b0);
    chk32("hold.pc_kept", redirect_pc, 32'h104);
    chk_cnt("hold.done");
    tick();
    chk_cnt("hold.after");

    // Asynchronous reset in the middle of a redirect.
    drive(vt[0]);
    tick();
    chk1("arst.pre", redirect_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_ctl("arst", 1'b0);
    chk32("arst.redirect_pc", redirect_pc, 32'h0);
    br_e = 0;
    mis_e = 0;
    chk_cnt("arst");
    ex_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(vt[2]);
    tick();
    br_e = 1;
    chk_cnt("arst.next");
    chk1("arst.next_rv", redirect_valid, 1'b0);
    ex_valid = 1'b0;

    // Saturation of the narrow-counter instance.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(vt[14]);
      tick();
      ex_valid = 1'b0;
      tick();
    end
    chk32("sat.br4", 32'(br4), 32'd15);
    chk32("sat.mis4", 32'(mis4), 32'd15);
    chk32("sat.br32", br_count, 32'd17);
    chk32("sat.mis32", mispred_count, 32'd17);
    drive(vt[13]);
    tick();
    ex_valid = 1'b0;
    chk32("sat.br4_hold", 32'(br4), 32'd15);
    chk32("sat.br32_next", br_count, 32'd18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage control-flow resolver for the RV32I 5-stage pipeline. It consumes the ALU's `{o,c,n,z}` flags from the `a - b` compare, decodes them per branch `funct3`, and checks the outcome against the fetch prediction. On a mispredict it issues a registered PC redirect with IF/ID flush and EX squash, and it keeps branch/mispredict statistics.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `CNT_W`, 32, statistics counter width

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  EX holds a real instruction
- `ex_is_branch`  in  1  conditional branch (B-type)
- `ex_is_jal`  in  1  JAL
- `ex_is_jalr`  in  1  JALR
- `ex_funct3`  in  3  branch condition select
- `alu_flags`  in  4  `{o,c,n,z}` from ALU subtract `rs1 - rs2`
- `ex_pc`  in  XLEN  PC of EX instruction
- `ex_imm`  in  XLEN  sign-extended immediate
- `ex_rs1`  in  XLEN  rs1 operand, forwarded
- `ex_pred_taken`  in  1  fetch predicted taken
- `ex_pred_target`  in  XLEN  fetch predicted target
- `stall`  in  1  pipeline hold from hazard unit
- `redirect_valid`  out  1  load `redirect_pc` into PC
- `redirect_pc`  out  XLEN  corrected fetch address
- `flush_if`  out  1  IF/ID register loads bubble at this edge
- `flush_id`  out  1  ID/EX register loads bubble at this edge
- `squash_ex`  out  1  current EX instruction must not write back
- `link_pc`  out  XLEN  combinational `ex_pc + 4`, used for JAL/JALR rd
- `br_count`  out  CNT_W  resolved control-flow instructions
- `mispred_count`  out  CNT_W  mispredicts

## Operation
- Condition decode, with `funct3` given as the mnemonic:
  - BEQ: `z`
  - BNE: `~z`
  - BLT: `n^o`
  - BGE: `~(n^o)`
  - BLTU: `~c`
  - BGEU: `c`
  - `funct3` 010 or 011: not taken, no redirect.
- Actual taken:
  - JAL and JALR: always taken.
  - Branch: the decoded condition.
- Target:
  - Branch or JAL: `ex_pc + ex_imm`.
  - JALR: `(ex_rs1 + ex_imm) & ~1`.
  - All sums are modulo 2^XLEN; wrap-around is legal and not flagged.
- Resolve event: `ex_valid & (branch|jal|jalr) & ~stall & state==IDLE`.
- Mispredict: `actual_taken != ex_pred_taken`, OR `actual_taken & (target != ex_pred_target)`.
- Corrected PC is `target` when taken, otherwise `ex_pc + 4`.
- State machine, with states IDLE and REDIRECT:
  - IDLE → REDIRECT on a resolve event that mispredicts. The corrected PC is captured into the `redirect_pc` register.
  - REDIRECT asserts `redirect_valid`, `flush_if`, `flush_id` and `squash_ex`.
  - REDIRECT → IDLE when `stall==0`. While `stall==1` it holds, with all outputs and `redirect_pc` frozen.
- In REDIRECT, EX contents are wrong-path. They are never evaluated, and a "mispredict" seen there is ignored.
- Counters increment once per resolve event; `mispred_count` also increments when that event mispredicts. Both saturate at all-ones and do not wrap.
- Each of `ex_is_branch`, `ex_is_jal` and `ex_is_jalr` is one-hot with the others. If more than one is set, priority is JALR > JAL > branch.

## Timing
- Reset (async assert, sync deassert at the pipeline level):
  - State IDLE.
  - `redirect_valid`, `flush_if`, `flush_id` and `squash_ex` are 0.
  - `redirect_pc` is 0.
  - Both counters are 0.
- Mispredict latency: resolve at cycle t; `redirect_valid`, the flushes and `squash_ex` are high in cycle t+1 and registered (no comb path from EX inputs).
- PC, IF/ID and ID/EX update at the end of t+1; EX at t+2 holds a bubble.
- Stall during REDIRECT:
  - Redirect stays asserted N+1 cycles for N stall cycles.
  - Exactly one redirect per mispredict.
  - Counters do not increment again.
- A resolve event coincident with `stall=1` is deferred. It is evaluated on the first unstalled cycle, when the same instruction is still in EX.
- `rst_n` low mid-REDIRECT aborts immediately to the reset values. No partial redirect survives.
- `link_pc` is purely combinational, with no latency.

## Structure
- Package `branch_pkg` holds:
  - `funct3` constants `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`, `F3_BLTU`, `F3_BGEU`.
  - State enum `br_state_t {IDLE, REDIRECT}`.
  - Flag bit-index constants `FLAG_O=3`, `FLAG_C=2`, `FLAG_N=1`, `FLAG_Z=0`, matching the ALU flag order.
- Sub-module `branch_cond`: combinational, `funct3` + flags → `taken`. It can be reused by a future ID-stage early resolver.

## Test plan
- BEQ with rs1=rs2=5 (ALU z=1), predicted not-taken, `ex_pc=0x100`, `imm=0x20` → cycle t+1: `redirect_valid=1`, `redirect_pc=0x120`, both flushes set, `mispred_count=1`.
- BLT/BLTU signed-vs-unsigned, rs1=0xFFFFFFFF, rs2=1:
  - BLT is taken.
  - BLTU is not taken.
  - With predictions matching each, no redirect; `br_count=2`.
- JALR, rs1=0x1003, imm=4, predicted target 0x1006 → `redirect_pc=0x1006`, no redirect. Predicted 0x1000 → redirect to 0x1006.
- Mispredict, then `stall` high 3 cycles → redirect asserted 4 cycles, single `mispred_count` increment, wrong-path EX mispredict ignored.
- `rst_n` pulsed low during REDIRECT → all outputs 0 in the same cycle. Next branch counts from `br_count=1`.
- Counter saturation with `CNT_W=4`: 17 resolves → `br_count=15`.
